// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - sequential 4x4 unsigned shift-and-add multiplier
//
// Purpose:
//   Multiplies two unsigned 4-bit operands. One multiplier bit is handled
//   per clock, so every operation takes exactly 4 RUN cycles with no early
//   exit. The 8-bit product is registered and held until the next
//   completion. An overflow flag shows a product that does not fit the
//   4-bit ALU result.
//
// Ports:
//   clk     in   1  rising-edge clock
//   resetN  in   1  synchronous active-low reset
//   start   in   1  multiply request, honoured only in IDLE
//   A       in   4  multiplicand (unsigned)
//   B       in   4  multiplier (unsigned)
//   busy    out  1  high during the 4 RUN cycles
//   done    out  1  one-cycle pulse when P/ovf have just been updated
//   P       out  8  registered product A*B
//   ovf     out  1  registered, high when P[7:4] != 0

module alu_seq_multiplier (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [7:0] P,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_mcand;
  logic [3:0] r_mplier;
  logic [7:0] r_acc;
  logic [1:0] r_count;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_p;
  logic       r_ovf;

  // Partial product for the multiplier bit selected by the iteration count.
  logic [7:0] w_addend;
  logic [7:0] w_acc_next;

  always_comb begin
    w_addend = 8'h00;
    if (r_mplier[r_count]) begin
      w_addend = {4'b0000, r_mcand} << r_count;
    end
    // 15*15 = 225 fits in 8 bits, so this sum never wraps.
    w_acc_next = r_acc + w_addend;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_mcand  <= 4'h0;
      r_mplier <= 4'h0;
      r_acc    <= 8'h00;
      r_count  <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= 8'h00;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // Operands are captured here only; later changes are ignored.
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= 8'h00;
            r_count  <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            // Final bit: publish the product on the same edge as the done pulse.
            r_p     <= w_acc_next;
            r_ovf   <= |w_acc_next[7:4];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // start is not queued here; a new request must arrive in IDLE.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // busy/done come straight from flops that track the state, so they are
  // glitch-free and mutually exclusive.
  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// tb/tb_alu_seq_multiplier.sv - scoreboard bench for alu_seq_multiplier

module tb_alu_seq_multiplier;

  logic       clk;
  logic       resetN;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  // Expected {P, ovf} per accepted operation, in acceptance order.
  logic [8:0] sb[$];

  alu_seq_multiplier dut (
    .clk   (clk),
    .resetN(resetN),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    sb.push_back({p, (p > 8'd15)});
  endtask

  // Result monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      logic [8:0] e;
      n_done++;
      check("busy_done_excl", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("product", {24'd0, P}, {24'd0, e[8:1]});
        check("ovf", {31'd0, ovf}, {31'd0, e[0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge with the DUT idle; returns at #1 after edge t+5.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit timing);
    int bcnt;
    int dat;
    A = a;
    B = b;
    start = 1'b1;
    push_exp(a, b);
    tick();
    start = 1'b0;
    A = 4'($urandom);
    B = 4'($urandom);
    bcnt = 0;
    dat = -1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      if (busy) bcnt++;
      if (done && dat < 0) dat = k;
    end
    if (timing) begin
      check("busy_cycles", bcnt, 4);
      check("done_edge", dat, 4);
      check("idle_after", {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    int d0;
    logic [3:0] pa[4];
    logic [3:0] pb[4];

    resetN = 1'b0;
    start  = 1'b0;
    A      = 4'h0;
    B      = 4'h0;

    // Reset with random inputs for two edges.
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom);
      A = 4'($urandom);
      B = 4'($urandom);
      tick();
    end
    check("rst_P", {24'd0, P}, 32'h00);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    resetN = 1'b1;
    start = 1'b0;
    tick();

    // Basic products, zero and identity, with cycle timing.
    do_op(4'd3, 4'd2, 1'b1);
    do_op(4'd13, 4'd11, 1'b1);
    do_op(4'd15, 4'd15, 1'b1);
    do_op(4'd0, 4'd9, 1'b1);
    do_op(4'd7, 4'd1, 1'b1);

    // Isolation: operand changes and start pulses during RUN/DONE are ignored.
    d0 = n_done;
    A = 4'd5;
    B = 4'd6;
    start = 1'b1;
    push_exp(4'd5, 4'd6);
    tick();
    A = 4'd15;
    B = 4'd15;
    for (int k = 1; k <= 5; k++) tick();
    start = 1'b0;
    tick();
    tick();
    check("iso_one_done", n_done - d0, 1);
    check("iso_idle", {30'd0, busy, done}, 32'd0);
    check("iso_P_hold", {24'd0, P}, 32'h1E);
    // P holds the previous result while the next operation runs.
    A = 4'd2;
    B = 4'd3;
    start = 1'b1;
    push_exp(4'd2, 4'd3);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("hold_P_run", {24'd0, P}, 32'h1E);
    for (int k = 0; k < 5; k++) tick();

    // Reset mid-operation: abandoned, no done pulse.
    d0 = n_done;
    A = 4'd9;
    B = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    check("midrst_P", {24'd0, P}, 32'h00);
    check("midrst_idle", {30'd0, busy, done}, 32'd0);
    for (int k = 0; k < 6; k++) tick();
    check("midrst_no_done", n_done - d0, 0);
    do_op(4'd2, 4'd4, 1'b1);

    // Back-to-back with start held high: accepts every 6 edges.
    pa = '{4'd6, 4'd11, 4'd1, 4'd14};
    pb = '{4'd7, 4'd12, 4'd15, 4'd9};
    A = pa[0];
    B = pb[0];
    start = 1'b1;
    push_exp(pa[0], pb[0]);
    tick();
    check("b2b_accept0", {31'd0, busy}, 32'd1);
    for (int j = 1; j < 4; j++) begin
      A = pa[j];
      B = pb[j];
      for (int k = 1; k <= 5; k++) tick();
      check("b2b_gap", {31'd0, busy}, 32'd0);
      push_exp(pa[j], pb[j]);
      tick();
      check("b2b_accept", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Exhaustive sweep; the monitor checks every product.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), 1'b0);
      end
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
